// File: rtl/control_pkg.sv
// Shared encodings for the RV32I control unit: opcodes, func3 values,
// immediate/ALU enums and the main-decoder payload.
package control_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned RES_W = 2;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SRL  = 3'b101;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;
    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;

    localparam logic [RES_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4 = 2'b10;
    localparam logic [RES_W-1:0] RES_IMM = 2'b11;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_type_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_e;

    // Main-decoder payload handed to the output/ALU-decode logic
    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        imm_type_e         imm_type;
        logic              alu_src;
        logic [RES_W-1:0]  result_src;
        alu_op_e           alu_op;
        logic              jump;
        logic              branch;
        logic              op_ok;
    } main_ctrl_t;

endpackage

// File: rtl/control_alu_dec.sv
// ALU decoder: maps alu_op/func3/func7[5] to an ALU operation and flags
// encodings the ALU does not implement.
module control_alu_dec
    import control_pkg::*;
(
    input  logic [1:0]      alu_op_i,
    input  logic [F3_W-1:0] func3_i,
    input  logic            func7_5_i,
    input  logic            op_5_i,
    output logic [2:0]      alu_control_o,
    output logic            illegal_alu_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        illegal_alu_o = 1'b0;
        case (alu_op_i)
            ALU_OP_ADD: alu_control_o = ALU_ADD;
            ALU_OP_SUB: alu_control_o = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (func3_i)
                    // op_5 distinguishes R-type from ADDI, whose func7 bits are immediate
                    F3_ADD:  alu_control_o = (op_5_i && func7_5_i) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_control_o = ALU_SLL;
                    F3_SLT:  alu_control_o = ALU_SLT;
                    F3_SLTU: illegal_alu_o = 1'b1;
                    F3_XOR:  alu_control_o = ALU_XOR;
                    F3_SRL:  alu_control_o = ALU_SRL;
                    F3_OR:   alu_control_o = ALU_OR;
                    F3_AND:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control.sv
// RV32I control unit: combinational main decoder, ALU decoder and branch
// resolution, plus a sticky flag recording any illegal instruction since reset.
module control
    import control_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  op_code,
    input  logic [F3_W-1:0]  func3,
    input  logic [F7_W-1:0]  func7,
    input  logic             zero,
    output logic             reg_write,
    output logic             mem_write,
    output logic [2:0]       imm_type,
    output logic [2:0]       alu_control,
    output logic             alu_src,
    output logic [RES_W-1:0] result_src,
    output logic             pc_src,
    output logic             illegal,
    output logic             illegal_seen
);

    main_ctrl_t dec;
    logic       illegal_alu;
    logic       illegal_br;
    logic       br_taken;
    logic       illegal_seen_q;
    logic       illegal_seen_d;
    logic       unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    // Main decoder
    always_comb begin
        dec            = '0;
        dec.imm_type   = IMM_I;
        dec.alu_op     = ALU_OP_ADD;
        dec.result_src = RES_ALU;
        case (op_code)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
                dec.op_ok      = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.imm_type  = IMM_S;
                dec.alu_src   = 1'b1;
                dec.op_ok     = 1'b1;
            end
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_OP_FUNCT;
                dec.op_ok     = 1'b1;
            end
            OP_ITYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OP_FUNCT;
                dec.op_ok     = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm_type = IMM_B;
                dec.alu_op   = ALU_OP_SUB;
                dec.branch   = 1'b1;
                dec.op_ok    = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.imm_type   = IMM_J;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.op_ok      = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.imm_type   = IMM_U;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_IMM;
                dec.op_ok      = 1'b1;
            end
            default: dec.op_ok = 1'b0;
        endcase
    end

    control_alu_dec u_alu_dec (
        .alu_op_i      (dec.alu_op),
        .func3_i       (func3),
        .func7_5_i     (func7[5]),
        .op_5_i        (op_code[5]),
        .alu_control_o (alu_control),
        .illegal_alu_o (illegal_alu)
    );

    // Only BEQ and BNE are supported branch conditions
    assign br_taken   = ((func3 == F3_BEQ) && zero) || ((func3 == F3_BNE) && !zero);
    assign illegal_br = dec.branch && !((func3 == F3_BEQ) || (func3 == F3_BNE));
    assign pc_src     = dec.jump || (dec.branch && br_taken);

    assign illegal    = !dec.op_ok || illegal_alu || illegal_br;

    // Illegal instructions must never commit architectural state
    assign reg_write  = dec.reg_write && !illegal;
    assign mem_write  = dec.mem_write && !illegal;
    assign imm_type   = dec.imm_type;
    assign alu_src    = dec.alu_src;
    assign result_src = dec.result_src;

    assign illegal_seen_d = illegal_seen_q || illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_control.sv
// Directed testbench for the RV32I control unit; expected values hand-derived
// from the instruction encodings.
module tb_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op_code = 7'b0000011;
    logic [2:0] func3 = 3'b000;
    logic [6:0] func7 = 7'b0000000;
    logic       zero = 1'b0;
    logic       reg_write;
    logic       mem_write;
    logic [2:0] imm_type;
    logic [2:0] alu_control;
    logic       alu_src;
    logic [1:0] result_src;
    logic       pc_src;
    logic       illegal;
    logic       illegal_seen;

    int n_cmp = 0;
    int n_err = 0;

    // {op_code, func3, func7, zero, expected}; expected packs
    // {reg_write, mem_write, imm_type, alu_control, alu_src, result_src, pc_src, illegal}
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic [12:0] exp;
    } vec_t;

    logic [12:0] obs;
    assign obs = {reg_write, mem_write, imm_type, alu_control, alu_src, result_src, pc_src, illegal};

    control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_code      (op_code),
        .func3        (func3),
        .func7        (func7),
        .zero         (zero),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .imm_type     (imm_type),
        .alu_control  (alu_control),
        .alu_src      (alu_src),
        .result_src   (result_src),
        .pc_src       (pc_src),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset;
        #1 rst_n = 1'b0;
        op_code = 7'b0000011; func3 = 3'b010; func7 = 7'b0; zero = 1'b0;
        #1;
        n_cmp++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL reset_seen: got %b, required 0", illegal_seen);
        end
        // Combinational decode keeps working while reset is held
        n_cmp++;
        if (obs !== 13'b1_0_000_000_1_01_0_0) begin
            n_err++; $display("FAIL reset_lw_decode: got %b, required %b", obs, 13'b1_0_000_000_1_01_0_0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL reset_release_seen: got %b, required 0", illegal_seen);
        end
    endtask

    task automatic test_load_store;
        vec_t v [3];
        v = '{'{7'b0000011, 3'b010, 7'b0000000, 1'b0, 13'b1_0_000_000_1_01_0_0},
              '{7'b0100011, 3'b010, 7'b0100000, 1'b1, 13'b0_1_001_000_1_00_0_0},
              '{7'b0100011, 3'b000, 7'b0000000, 1'b0, 13'b0_1_001_000_1_00_0_0}};
        foreach (v[i]) begin
            @(negedge clk);
            op_code = v[i].op; func3 = v[i].f3; func7 = v[i].f7; zero = v[i].z;
            #1;
            n_cmp++;
            if (obs !== v[i].exp) begin
                n_err++; $display("FAIL load_store[%0d]: got %b, required %b", i, obs, v[i].exp);
            end
        end
    endtask

    task automatic test_rtype;
        vec_t v [9];
        v = '{'{7'b0110011, 3'b000, 7'b0000000, 1'b0, 13'b1_0_000_000_0_00_0_0},
              '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 13'b1_0_000_001_0_00_0_0},
              '{7'b0110011, 3'b111, 7'b0000000, 1'b0, 13'b1_0_000_010_0_00_0_0},
              '{7'b0110011, 3'b110, 7'b0000000, 1'b1, 13'b1_0_000_011_0_00_0_0},
              '{7'b0110011, 3'b100, 7'b0000000, 1'b0, 13'b1_0_000_100_0_00_0_0},
              '{7'b0110011, 3'b010, 7'b0000000, 1'b0, 13'b1_0_000_101_0_00_0_0},
              '{7'b0110011, 3'b001, 7'b0000000, 1'b0, 13'b1_0_000_110_0_00_0_0},
              '{7'b0110011, 3'b101, 7'b0100000, 1'b0, 13'b1_0_000_111_0_00_0_0},
              '{7'b0110011, 3'b011, 7'b0000000, 1'b0, 13'b0_0_000_000_0_00_0_1}};
        foreach (v[i]) begin
            @(negedge clk);
            op_code = v[i].op; func3 = v[i].f3; func7 = v[i].f7; zero = v[i].z;
            #1;
            n_cmp++;
            if (obs !== v[i].exp) begin
                n_err++; $display("FAIL rtype[%0d]: got %b, required %b", i, obs, v[i].exp);
            end
        end
    endtask

    task automatic test_itype;
        vec_t v [4];
        v = '{'{7'b0010011, 3'b000, 7'b0100000, 1'b0, 13'b1_0_000_000_1_00_0_0},
              '{7'b0010011, 3'b111, 7'b0000000, 1'b0, 13'b1_0_000_010_1_00_0_0},
              '{7'b0010011, 3'b101, 7'b0100000, 1'b0, 13'b1_0_000_111_1_00_0_0},
              '{7'b0010011, 3'b011, 7'b0000000, 1'b0, 13'b0_0_000_000_1_00_0_1}};
        foreach (v[i]) begin
            @(negedge clk);
            op_code = v[i].op; func3 = v[i].f3; func7 = v[i].f7; zero = v[i].z;
            #1;
            n_cmp++;
            if (obs !== v[i].exp) begin
                n_err++; $display("FAIL itype[%0d]: got %b, required %b", i, obs, v[i].exp);
            end
        end
    endtask

    task automatic test_branch;
        vec_t v [6];
        v = '{'{7'b1100011, 3'b000, 7'b0000000, 1'b1, 13'b0_0_010_001_0_00_1_0},
              '{7'b1100011, 3'b000, 7'b0000000, 1'b0, 13'b0_0_010_001_0_00_0_0},
              '{7'b1100011, 3'b001, 7'b0000000, 1'b0, 13'b0_0_010_001_0_00_1_0},
              '{7'b1100011, 3'b001, 7'b0000000, 1'b1, 13'b0_0_010_001_0_00_0_0},
              '{7'b1100011, 3'b100, 7'b0000000, 1'b1, 13'b0_0_010_001_0_00_0_1},
              '{7'b1100011, 3'b111, 7'b0000000, 1'b0, 13'b0_0_010_001_0_00_0_1}};
        foreach (v[i]) begin
            @(negedge clk);
            op_code = v[i].op; func3 = v[i].f3; func7 = v[i].f7; zero = v[i].z;
            #1;
            n_cmp++;
            if (obs !== v[i].exp) begin
                n_err++; $display("FAIL branch[%0d]: got %b, required %b", i, obs, v[i].exp);
            end
        end
    endtask

    task automatic test_jal_lui;
        vec_t v [3];
        v = '{'{7'b1101111, 3'b000, 7'b0000000, 1'b0, 13'b1_0_100_000_0_10_1_0},
              '{7'b1101111, 3'b011, 7'b0100000, 1'b1, 13'b1_0_100_000_0_10_1_0},
              '{7'b0110111, 3'b101, 7'b0100000, 1'b0, 13'b1_0_011_000_1_11_0_0}};
        foreach (v[i]) begin
            @(negedge clk);
            op_code = v[i].op; func3 = v[i].f3; func7 = v[i].f7; zero = v[i].z;
            #1;
            n_cmp++;
            if (obs !== v[i].exp) begin
                n_err++; $display("FAIL jal_lui[%0d]: got %b, required %b", i, obs, v[i].exp);
            end
        end
    endtask

    task automatic test_illegal_opcode;
        vec_t v [4];
        v = '{'{7'b0000000, 3'b000, 7'b0000000, 1'b0, 13'b0_0_000_000_0_00_0_1},
              '{7'b1111111, 3'b111, 7'b1111111, 1'b1, 13'b0_0_000_000_0_00_0_1},
              '{7'b1100111, 3'b000, 7'b0000000, 1'b1, 13'b0_0_000_000_0_00_0_1},
              '{7'b0010111, 3'b000, 7'b0100000, 1'b0, 13'b0_0_000_000_0_00_0_1}};
        foreach (v[i]) begin
            @(negedge clk);
            op_code = v[i].op; func3 = v[i].f3; func7 = v[i].f7; zero = v[i].z;
            #1;
            n_cmp++;
            if (obs !== v[i].exp) begin
                n_err++; $display("FAIL illegal_op[%0d]: got %b, required %b", i, obs, v[i].exp);
            end
        end
    endtask

    task automatic test_sticky;
        @(negedge clk);
        rst_n = 1'b0;
        op_code = 7'b0000011; func3 = 3'b010; func7 = 7'b0; zero = 1'b0;
        #1;
        n_cmp++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL sticky_clear: got %b, required 0", illegal_seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL sticky_legal_stays_low: got %b, required 0", illegal_seen);
        end
        @(negedge clk);
        op_code = 7'b0000000;
        #1;
        n_cmp++;
        if ({illegal, illegal_seen} !== 2'b10) begin
            n_err++; $display("FAIL sticky_before_edge: got %b, required 10", {illegal, illegal_seen});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (illegal_seen !== 1'b1) begin
            n_err++; $display("FAIL sticky_set: got %b, required 1", illegal_seen);
        end
        @(negedge clk);
        op_code = 7'b0110011;
        @(posedge clk); #1;
        n_cmp++;
        if (illegal_seen !== 1'b1) begin
            n_err++; $display("FAIL sticky_hold: got %b, required 1", illegal_seen);
        end
        // Mid-cycle reset must clear the flag without a clock edge
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL sticky_async_clear: got %b, required 0", illegal_seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL sticky_after_reset: got %b, required 0", illegal_seen);
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_rtype();
        test_itype();
        test_branch();
        test_jal_lui();
        test_illegal_opcode();
        test_sticky();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
